// File: rtl/snake_pkg.sv
// Shared definitions for the snake game blocks: grid defaults, coordinate widths,
// placer state encoding and the candidate-scrambling LFSR.
package snake_pkg;

    localparam int GRID_W_DEF = 40;
    localparam int GRID_H_DEF = 30;
    localparam int X_W        = 6;
    localparam int Y_W        = 5;
    localparam int SEED_W     = 12;

    // Feedback taps on bits 11, 5, 3 and 0.
    localparam logic [SEED_W-1:0] LFSR_TAPS = 12'h829;
    localparam logic [SEED_W-1:0] LFSR_ZERO = 12'hACE;

    typedef enum logic [2:0] {
        IDLE,
        DIV_X,
        DIV_Y,
        QUERY,
        CHECK,
        DONE
    } state_t;

    function automatic logic [SEED_W-1:0] lfsr_next(input logic [SEED_W-1:0] c);
        if (c == '0) begin
            return LFSR_ZERO;
        end
        return {c[SEED_W-2:0], ^(c & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/grid_mapper.sv
// Sequential subtract-divider mapping a 12-bit candidate onto the grid:
// x = cand mod GRID_W, y = (cand / GRID_W) mod GRID_H, one compare-subtract per cycle.
module grid_mapper
    import snake_pkg::*;
#(
    parameter int GRID_W = GRID_W_DEF,
    parameter int GRID_H = GRID_H_DEF
) (
    input  logic              OSC,
    input  logic              rst,
    input  logic              start,
    input  logic [SEED_W-1:0] cand,
    output logic              x_done,
    output logic              done,
    output logic [X_W-1:0]    x,
    output logic [Y_W-1:0]    y
);

    localparam logic [SEED_W-1:0] W_C = SEED_W'(GRID_W);
    localparam logic [SEED_W-1:0] H_C = SEED_W'(GRID_H);

    logic [SEED_W-1:0] r;
    logic [SEED_W-1:0] q;
    logic              active;
    logic              phase_y;

    assign x_done = active && !phase_y && (r < W_C);
    assign done   = active && phase_y && (r < H_C);
    // y is the remainder itself; it is only meaningful while done is high.
    assign y      = r[Y_W-1:0];

    always_ff @(posedge OSC) begin
        if (rst) begin
            r       <= '0;
            q       <= '0;
            active  <= 1'b0;
            phase_y <= 1'b0;
            x       <= '0;
        end else if (start) begin
            r       <= cand;
            q       <= '0;
            active  <= 1'b1;
            phase_y <= 1'b0;
        end else if (active) begin
            if (!phase_y) begin
                if (r >= W_C) begin
                    r <= r - W_C;
                    q <= q + 1'b1;
                end else begin
                    x       <= r[X_W-1:0];
                    r       <= q;
                    phase_y <= 1'b1;
                end
            end else if (r >= H_C) begin
                r <= r - H_C;
            end else begin
                active <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/food_placer.sv
// Places food on a free grid cell derived from randomseed, retrying with an LFSR on hits.
// Optional attempt cap with fail pulse: define FOOD_RETRY_LIMIT_EN.
//   state | meaning
//   IDLE  | waiting for req
//   DIV_X | mapper computing column
//   DIV_Y | mapper computing row
//   QUERY | occupancy strobe out
//   CHECK | occ_hit sampled
//   DONE  | food_valid pulse
module food_placer
    import snake_pkg::*;
#(
    parameter int GRID_W = GRID_W_DEF,
    parameter int GRID_H = GRID_H_DEF
`ifdef FOOD_RETRY_LIMIT_EN
    ,
    parameter int MAX_TRIES = 15
`endif
) (
    input  logic              OSC,
    input  logic              rst,
    input  logic [SEED_W-1:0] randomseed,
    input  logic              req,
    output logic              busy,
    output logic              occ_query,
    output logic [X_W-1:0]    occ_x,
    output logic [Y_W-1:0]    occ_y,
    input  logic              occ_hit,
    output logic [X_W-1:0]    food_x,
    output logic [Y_W-1:0]    food_y,
`ifdef FOOD_RETRY_LIMIT_EN
    output logic              fail,
`endif
    output logic              food_valid
);

    state_t            state, state_n;
    logic [SEED_W-1:0] cand;
    logic [SEED_W-1:0] cand_lfsr;
    logic [SEED_W-1:0] map_cand;
    logic              map_start;
    logic              map_x_done;
    logic              map_done;
    logic [X_W-1:0]    map_x;
    logic [Y_W-1:0]    map_y;
    logic              capped;

`ifdef FOOD_RETRY_LIMIT_EN
    logic [7:0] tries;
    assign capped = (tries == 8'(MAX_TRIES));
`else
    assign capped = 1'b0;
`endif

    assign cand_lfsr  = lfsr_next(cand);
    assign busy       = (state != IDLE);
    assign occ_query  = (state == QUERY);
    assign food_valid = (state == DONE);

    grid_mapper #(
        .GRID_W(GRID_W),
        .GRID_H(GRID_H)
    ) u_mapper (
        .OSC   (OSC),
        .rst   (rst),
        .start (map_start),
        .cand  (map_cand),
        .x_done(map_x_done),
        .done  (map_done),
        .x     (map_x),
        .y     (map_y)
    );

    always_ff @(posedge OSC) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n   = state;
        map_start = 1'b0;
        map_cand  = randomseed;
        case (state)
            IDLE: begin
                if (req) begin
                    state_n   = DIV_X;
                    map_start = 1'b1;
                end
            end
            DIV_X: if (map_x_done) state_n = DIV_Y;
            DIV_Y: if (map_done) state_n = QUERY;
            QUERY: state_n = CHECK;
            CHECK: begin
                if (!occ_hit) begin
                    state_n = DONE;
                end else if (capped) begin
                    state_n = IDLE;
                end else begin
                    state_n   = DIV_X;
                    map_start = 1'b1;
                    map_cand  = cand_lfsr;
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge OSC) begin
        if (rst) begin
            cand   <= '0;
            occ_x  <= '0;
            occ_y  <= '0;
            food_x <= X_W'(GRID_W / 2);
            food_y <= Y_W'(GRID_H / 2);
`ifdef FOOD_RETRY_LIMIT_EN
            tries  <= 8'd1;
            fail   <= 1'b0;
`endif
        end else begin
            if (map_start) begin
                cand <= map_cand;
            end
            // The query coordinates double as the holding register for the candidate cell.
            if (state == DIV_Y && map_done) begin
                occ_x <= map_x;
                occ_y <= map_y;
            end
            if (state == CHECK && !occ_hit) begin
                food_x <= occ_x;
                food_y <= occ_y;
            end
`ifdef FOOD_RETRY_LIMIT_EN
            fail <= (state == CHECK) && occ_hit && capped;
            if (state == IDLE) begin
                tries <= 8'd1;
            end else if (map_start) begin
                tries <= tries + 8'd1;
            end
`endif
        end
    end

endmodule
